kv_txn_arbiter: RTL and testbench

- Shares the single key-value store command port between N_REQ packet assemblers (create, update, delete, read front-ends).
- Each requester holds a decoded transaction: opcode, 32-bit key, 32-bit value. The arbiter grants round-robin and issues one transaction at a time to the store.
- Waits for completion or timeout, then returns status and read data to the granted requester with a one-cycle ack.

---
 rtl/kv_txn_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_kv_txn_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_txn_arbiter.sv
// Round-robin arbiter sharing one key-value store command port between N_REQ
// transaction front-ends; issues one command at a time and returns status/data with a one-cycle ack.
module kv_txn_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 tick_in,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_key,
    input  logic [32*N_REQ-1:0]  req_value,
    output logic [N_REQ-1:0]     ack,
    output logic [1:0]           resp_status,
    output logic [31:0]          resp_data,
    output logic                 busy,
    output logic                 st_valid,
    output logic [1:0]           st_op,
    output logic [31:0]          st_key,
    output logic [31:0]          st_value,
    input  logic                 st_ready,
    input  logic                 st_done,
    input  logic                 st_err,
    input  logic [31:0]          st_rdata
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   N_REQ_W   = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [16:0]      TIMEOUT_W = 17'(TIMEOUT);

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_ST_ERR  = 2'd1;
    localparam logic [1:0] STATUS_BAD_OP  = 2'd2;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [15:0]        tmo_cnt_q, tmo_cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [1:0]         resp_status_q, resp_status_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               st_valid_q, st_valid_d;
    logic [1:0]         st_op_q, st_op_d;
    logic [31:0]        st_key_q, st_key_d;
    logic [31:0]        st_value_q, st_value_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W:0]     scan_sum;
    logic [1:0]         pick_op;
    logic [31:0]        pick_key;
    logic [31:0]        pick_value;
    logic [16:0]        tmo_cnt_inc;
    logic               tmo_hit;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vec[i] = (PTR_W'(i) == idx);
        end
        return vec;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    endfunction

    // Round-robin scan starting at rr_ptr, wrapping past the last requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= N_REQ_W) begin
                scan_sum = scan_sum - N_REQ_W;
            end
            if (!pick_found && req[scan_sum[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        pick_op    = '0;
        pick_key   = '0;
        pick_value = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == pick_idx) begin
                pick_op    = req_op[2*i +: 2];
                pick_key   = req_key[32*i +: 32];
                pick_value = req_value[32*i +: 32];
            end
        end
    end

    assign tmo_cnt_inc = {1'b0, tmo_cnt_q} + 17'd1;
    assign tmo_hit     = (tmo_cnt_inc >= TIMEOUT_W);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        ack_d         = '0;
        resp_status_d = resp_status_q;
        resp_data_d   = resp_data_q;
        st_valid_d    = st_valid_q;
        st_op_d       = st_op_q;
        st_key_d      = st_key_q;
        st_value_d    = st_value_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d      = pick_idx;
                    rr_ptr_d   = ptr_after(pick_idx);
                    st_op_d    = pick_op;
                    st_key_d   = pick_key;
                    st_value_d = pick_value;
                    if (pick_op == 2'd0) begin
                        // Invalid opcode is answered locally; the store never sees it.
                        resp_status_d = STATUS_BAD_OP;
                        resp_data_d   = '0;
                        ack_d         = onehot(pick_idx);
                        state_d       = RESP;
                    end else begin
                        st_valid_d = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (st_valid_q && st_ready) begin
                    st_valid_d = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_inc[15:0];
                // Completion takes priority over a timeout landing in the same cycle.
                if (st_done) begin
                    resp_status_d = st_err ? STATUS_ST_ERR : STATUS_OK;
                    resp_data_d   = st_rdata;
                    ack_d         = onehot(gnt_q);
                    state_d       = RESP;
                end else if (tmo_hit) begin
                    resp_status_d = STATUS_TIMEOUT;
                    resp_data_d   = '0;
                    ack_d         = onehot(gnt_q);
                    state_d       = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge tick_in or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            tmo_cnt_q     <= '0;
            ack_q         <= '0;
            resp_status_q <= '0;
            resp_data_q   <= '0;
            st_valid_q    <= 1'b0;
            st_op_q       <= '0;
            st_key_q      <= '0;
            st_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            ack_q         <= ack_d;
            resp_status_q <= resp_status_d;
            resp_data_q   <= resp_data_d;
            st_valid_q    <= st_valid_d;
            st_op_q       <= st_op_d;
            st_key_q      <= st_key_d;
            st_value_q    <= st_value_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign ack         = ack_q;
    assign resp_status = resp_status_q;
    assign resp_data   = resp_data_q;
    assign st_valid    = st_valid_q;
    assign st_op       = st_op_q;
    assign st_key      = st_key_q;
    assign st_value    = st_value_q;

endmodule

// File: tb/tb_kv_txn_arbiter.sv
// Directed bench for kv_txn_arbiter: latency, round-robin order, bad opcode,
// back-pressure, timeout/priority and asynchronous reset.
module tb_kv_txn_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 8;

    logic                tick_in = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [2*N_REQ-1:0]  req_op;
    logic [32*N_REQ-1:0] req_key;
    logic [32*N_REQ-1:0] req_value;
    logic [N_REQ-1:0]    ack;
    logic [1:0]          resp_status;
    logic [31:0]         resp_data;
    logic                busy;
    logic                st_valid;
    logic [1:0]          st_op;
    logic [31:0]         st_key;
    logic [31:0]         st_value;
    logic                st_ready;
    logic                st_done;
    logic                st_err;
    logic [31:0]         st_rdata;

    int checks = 0;
    int errors = 0;

    kv_txn_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .tick_in     (tick_in),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .req_key     (req_key),
        .req_value   (req_value),
        .ack         (ack),
        .resp_status (resp_status),
        .resp_data   (resp_data),
        .busy        (busy),
        .st_valid    (st_valid),
        .st_op       (st_op),
        .st_key      (st_key),
        .st_value    (st_value),
        .st_ready    (st_ready),
        .st_done     (st_done),
        .st_err      (st_err),
        .st_rdata    (st_rdata)
    );

    always #5 tick_in = ~tick_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tick_in);
        #1;
    endtask

    task automatic set_payload(input int i, input logic [1:0] op, input logic [31:0] key,
                               input logic [31:0] value);
        req_op[2*i +: 2]     = op;
        req_key[32*i +: 32]  = key;
        req_value[32*i +: 32] = value;
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        req_op    = '0;
        req_key   = '0;
        req_value = '0;
        st_ready  = 1'b0;
        st_done   = 1'b0;
        st_err    = 1'b0;
        st_rdata  = '0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_ack",      32'(ack), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_st_valid", 32'(st_valid), 32'h0);
        chk("rst_status",   32'(resp_status), 32'h0);
        chk("rst_key",      st_key, 32'h0);
        step();
        rst = 1'b0;

        // Single request, minimum latency
        set_payload(0, 2'd1, 32'h0000_00AA, 32'h0000_1234);
        req      = 4'b0001;
        st_ready = 1'b1;
        step();
        chk("t1_st_valid", 32'(st_valid), 32'h1);
        chk("t1_st_key",   st_key, 32'h0000_00AA);
        chk("t1_st_value", st_value, 32'h0000_1234);
        chk("t1_st_op",    32'(st_op), 32'h1);
        chk("t1_ack_c2",   32'(ack), 32'h0);
        step();
        chk("t1_accept_valid", 32'(st_valid), 32'h0);
        chk("t1_ack_c3",       32'(ack), 32'h0);
        st_done  = 1'b1;
        st_rdata = 32'h0000_0055;
        step();
        chk("t1_ack",    32'(ack), 32'h1);
        chk("t1_status", 32'(resp_status), 32'h0);
        chk("t1_rdata",  resp_data, 32'h0000_0055);
        st_done = 1'b0;
        req     = 4'b0000;
        step();
        chk("t1_ack_off", 32'(ack), 32'h0);
        chk("t1_idle",    32'(busy), 32'h0);

        // Reset while waiting for the store
        set_payload(1, 2'd2, 32'h0000_0011, 32'h0000_0022);
        req = 4'b0010;
        step();
        chk("t6_grant1_key", st_key, 32'h0000_0011);
        step();
        chk("t6_in_wait", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_ack",      32'(ack), 32'h0);
        chk("t6_busy",     32'(busy), 32'h0);
        chk("t6_st_valid", 32'(st_valid), 32'h0);
        chk("t6_st_op",    32'(st_op), 32'h0);
        chk("t6_st_key",   st_key, 32'h0);
        chk("t6_st_value", st_value, 32'h0);
        chk("t6_rdata",    resp_data, 32'h0);
        rst = 1'b0;

        // All four requesting: grants rotate 0,1,2,3,0 after rr_ptr reset
        set_payload(0, 2'd1, 32'h0000_0100, 32'h0000_1000);
        set_payload(1, 2'd2, 32'h0000_0101, 32'h0000_1001);
        set_payload(2, 2'd3, 32'h0000_0102, 32'h0000_1002);
        set_payload(3, 2'd1, 32'h0000_0103, 32'h0000_1003);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % N_REQ;
            step();
            chk("fair_valid", 32'(st_valid), 32'h1);
            chk("fair_key",   st_key, 32'h0000_0100 + 32'(g));
            step();
            chk("fair_wait_ack", 32'(ack), 32'h0);
            st_done  = 1'b1;
            st_rdata = 32'h0000_0200 + 32'(g);
            step();
            chk("fair_ack",  32'(ack), 32'(1 << g));
            chk("fair_data", resp_data, 32'h0000_0200 + 32'(g));
            st_done = 1'b0;
            step();
            chk("fair_ack_off", 32'(ack), 32'h0);
        end
        req = 4'b0000;
        step();

        // Invalid opcode from requester 2
        set_payload(2, 2'd0, 32'h0000_0033, 32'h0000_0044);
        req = 4'b0100;
        step();
        chk("t3_ack",      32'(ack), 32'h4);
        chk("t3_status",   32'(resp_status), 32'h2);
        chk("t3_st_valid", 32'(st_valid), 32'h0);
        req = 4'b0000;
        step();
        chk("t3_ack_off",   32'(ack), 32'h0);
        chk("t3_st_valid2", 32'(st_valid), 32'h0);
        chk("t3_idle",      32'(busy), 32'h0);

        // Back-pressure: st_ready low for 10 cycles, stray st_done ignored
        set_payload(3, 2'd3, 32'hCAFE_0003, 32'h0BAD_0003);
        st_ready = 1'b0;
        req      = 4'b1000;
        step();
        set_payload(3, 2'd1, 32'hFFFF_FFFF, 32'hEEEE_EEEE);
        for (int j = 0; j < 10; j++) begin
            chk("t4_hold_valid", 32'(st_valid), 32'h1);
            chk("t4_hold_key",   st_key, 32'hCAFE_0003);
            chk("t4_hold_value", st_value, 32'h0BAD_0003);
            st_done = (j == 4);
            step();
        end
        st_done = 1'b0;
        chk("t4_hold_op",   32'(st_op), 32'h3);
        chk("t4_no_ack",    32'(ack), 32'h0);
        st_ready = 1'b1;
        step();
        chk("t4_accept_valid", 32'(st_valid), 32'h0);
        st_done  = 1'b1;
        st_err   = 1'b1;
        st_rdata = 32'h0000_0077;
        step();
        chk("t4_ack",    32'(ack), 32'h8);
        chk("t4_status", 32'(resp_status), 32'h1);
        chk("t4_rdata",  resp_data, 32'h0000_0077);
        st_done = 1'b0;
        st_err  = 1'b0;
        req     = 4'b0000;
        step();

        // Timeout: store never completes
        set_payload(0, 2'd1, 32'h0000_0500, 32'h0000_0600);
        req = 4'b0001;
        step();
        chk("t5_valid", 32'(st_valid), 32'h1);
        step();
        for (int j = 0; j < TIMEOUT - 1; j++) begin
            step();
            chk("t5_wait_ack", 32'(ack), 32'h0);
        end
        step();
        chk("t5_ack",    32'(ack), 32'h1);
        chk("t5_status", 32'(resp_status), 32'h3);
        chk("t5_rdata",  resp_data, 32'h0);
        req = 4'b0000;
        step();
        chk("t5_ack_off", 32'(ack), 32'h0);

        // st_done on the timeout cycle wins
        req = 4'b0001;
        step();
        step();
        for (int j = 0; j < TIMEOUT - 1; j++) begin
            step();
            chk("t5b_wait_ack", 32'(ack), 32'h0);
        end
        st_done  = 1'b1;
        st_err   = 1'b0;
        st_rdata = 32'hDEAD_BEEF;
        step();
        chk("t5b_ack",    32'(ack), 32'h1);
        chk("t5b_status", 32'(resp_status), 32'h0);
        chk("t5b_rdata",  resp_data, 32'hDEAD_BEEF);
        st_done = 1'b0;
        req     = 4'b0000;
        step();
        chk("t5b_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
